// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage in front of a combinational 16-bit instruction
//               memory. Owns the PC, captures each returned word into an
//               IF/ID register with a valid/ready handshake toward decode, and
//               handles start-up, stalls, redirects, halt words and PCs that
//               run off the end of the memory.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          MEM_DEPTH = 1000,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  output logic        halted,
  output logic        addr_err,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Memory depth widened so the PC comparison is done without truncation.
  localparam logic [31:0] c_mem_depth = MEM_DEPTH;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] w_pc_nxt;
  logic        r_out_valid;
  logic        w_out_valid_nxt;
  logic [15:0] r_out_instr;
  logic [15:0] w_out_instr_nxt;
  logic [15:0] r_out_pc;
  logic [15:0] w_out_pc_nxt;
  logic [15:0] r_fetch_count;
  logic [15:0] w_fetch_count_nxt;
  logic        r_addr_err;
  logic        w_addr_err_nxt;

  logic        w_fetch_en;
  logic        w_pc_oob;
  logic        w_is_halt;

  // The output register can take a new word when it is empty or being drained.
  assign w_fetch_en = !r_out_valid || out_ready;
  assign w_pc_oob   = ({16'd0, r_pc} >= c_mem_depth);
  assign w_is_halt  = (imem_data == HALT_WORD);

  // State register; reset returns the unit to IDLE regardless of the clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-datapath decode, in per-cycle priority order.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_out_valid_nxt   = r_out_valid;
    w_out_instr_nxt   = r_out_instr;
    w_out_pc_nxt      = r_out_pc;
    w_fetch_count_nxt = r_fetch_count;
    w_addr_err_nxt    = r_addr_err;

    case (r_state)
      ST_IDLE: begin
        // Redirects are meaningless before fetching has begun.
        if (start) begin
          w_pc_nxt    = RESET_PC;
          w_state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        if (redirect_valid) begin
          // Flush: the word in the output register (if any) is dropped, or
          // consumed by decode if it happens to be accepted this cycle.
          w_out_valid_nxt = 1'b0;
          w_pc_nxt        = redirect_target;
        end else if (w_pc_oob && w_fetch_en) begin
          w_state_nxt    = ST_HALTED;
          w_addr_err_nxt = 1'b1;
          if (out_ready) begin
            w_out_valid_nxt = 1'b0;
          end
        end else if (w_fetch_en) begin
          w_out_instr_nxt   = imem_data;
          w_out_pc_nxt      = r_pc;
          w_out_valid_nxt   = 1'b1;
          w_fetch_count_nxt = r_fetch_count + 16'd1;
          // A halt word parks the PC on itself so imem_addr shows where we stopped.
          if (w_is_halt) begin
            w_state_nxt = ST_HALTED;
          end else begin
            w_pc_nxt = r_pc + 16'd1;
          end
        end
        // Otherwise decode is stalling us and everything holds.
      end

      ST_HALTED: begin
        if (redirect_valid) begin
          w_pc_nxt        = redirect_target;
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = ST_RUN;
        end else if (out_ready) begin
          w_out_valid_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath registers: PC, IF/ID register, capture counter, sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_out_valid   <= 1'b0;
      r_out_instr   <= 16'd0;
      r_out_pc      <= 16'd0;
      r_fetch_count <= 16'd0;
      r_addr_err    <= 1'b0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_instr   <= w_out_instr_nxt;
      r_out_pc      <= w_out_pc_nxt;
      r_fetch_count <= w_fetch_count_nxt;
      r_addr_err    <= w_addr_err_nxt;
    end
  end

  assign imem_addr   = r_pc;
  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_pc      = r_out_pc;
  assign halted      = (r_state == ST_HALTED);
  assign addr_err    = r_addr_err;
  assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit against a cycle-level
//               behavioural model of the fetch rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        halted;
  logic        addr_err;
  logic [15:0] fetch_count;

  logic [15:0] mem [0:1023];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  int          m_mode;
  logic [15:0] m_pc;
  logic        m_valid;
  logic [15:0] m_instr;
  logic [15:0] m_opc;
  logic [15:0] m_count;
  logic        m_err;
  logic [15:0] c0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[9:0]];

  instr_fetch_unit #(
    .RESET_PC (16'h0000),
    .MEM_DEPTH(1000),
    .HALT_WORD(16'hFFFF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted),
    .addr_err       (addr_err),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_pc    = 16'h0000;
    m_valid = 1'b0;
    m_instr = 16'h0000;
    m_opc   = 16'h0000;
    m_count = 16'h0000;
    m_err   = 1'b0;
  endtask

  // One clock edge of the fetch rules, applied to the current inputs.
  task automatic model_edge();
    bit          fe;
    logic [15:0] word;
    fe   = !m_valid || out_ready;
    word = mem[m_pc[9:0]];
    if (m_mode == M_IDLE) begin
      if (start) begin
        m_pc   = 16'h0000;
        m_mode = M_RUN;
      end
    end else if (m_mode == M_RUN) begin
      if (redirect_valid) begin
        m_valid = 1'b0;
        m_pc    = redirect_target;
      end else if (int'(m_pc) >= 1000 && fe) begin
        m_mode = M_HALT;
        m_err  = 1'b1;
        if (out_ready) m_valid = 1'b0;
      end else if (fe) begin
        m_instr = word;
        m_opc   = m_pc;
        m_valid = 1'b1;
        m_count = m_count + 16'd1;
        if (word == 16'hFFFF) m_mode = M_HALT;
        else m_pc = m_pc + 16'd1;
      end
    end else begin
      if (redirect_valid) begin
        m_pc    = redirect_target;
        m_valid = 1'b0;
        m_mode  = M_RUN;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    check("imem_addr", 32'(imem_addr), 32'(m_pc));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_instr", 32'(out_instr), 32'(m_instr));
    check("out_pc", 32'(out_pc), 32'(m_opc));
    check("halted", 32'(halted), 32'(m_mode == M_HALT));
    check("addr_err", 32'(addr_err), 32'(m_err));
    check("fetch_count", 32'(fetch_count), 32'(m_count));
  endtask

  task automatic step(input logic st, input logic rv, input logic [15:0] rt, input logic rdy);
    start           = st;
    redirect_valid  = rv;
    redirect_target = rt;
    out_ready       = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asserts reset between clock edges and checks that it takes effect at once.
  task automatic do_reset();
    start          = 1'b0;
    redirect_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #2;
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w == 16'hFFFF) w = 16'h0000;
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = rand_word();
    mem[0]   = 16'h8808;
    mem[1]   = 16'h05F4;
    mem[2]   = 16'h8902;
    mem[255] = 16'h8783;

    rst             = 1'b1;
    start           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 16'h0000;
    out_ready       = 1'b0;
    #2;
    model_reset();
    check_all();
    check("rst_valid", 32'(out_valid), 32'd0);
    #10;
    rst = 1'b0;

    // Start-up and full-rate fetch
    step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check("first_instr", 32'(out_instr), 32'h8808);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check("second_instr", 32'(out_instr), 32'h05F4);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check("third_instr", 32'(out_instr), 32'h8902);
    check("third_pc", 32'(out_pc), 32'd2);
    check("count3", 32'(fetch_count), 32'd3);

    // Backpressure
    do_reset();
    step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    check("stall_instr", 32'(out_instr), 32'h8808);
    check("stall_addr", 32'(imem_addr), 32'd1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check("release_instr", 32'(out_instr), 32'h05F4);
    check("release_pc", 32'(out_pc), 32'd1);

    // Redirect while a word at pc 5 is pending
    mem[4] = 16'h1234;
    do_reset();
    step(1'b1, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1);
      if (out_valid && out_pc == 16'd5) break;
    end
    check("reach_pc5", 32'(out_pc), 32'd5);
    step(1'b0, 1'b1, 16'd255, 1'b0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("redir_addr", 32'(imem_addr), 32'd255);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check("redir_instr", 32'(out_instr), 32'h8783);
    check("redir_pc", 32'(out_pc), 32'd255);

    // Halt word at address 4
    mem[4] = 16'hFFFF;
    step(1'b0, 1'b1, 16'd0, 1'b1);
    c0 = m_count;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_pc", 32'(out_pc), 32'd4);
    check("halt_addr", 32'(imem_addr), 32'd4);
    check("halt_count", 32'(fetch_count), 32'(c0 + 16'd5));
    step(1'b1, 1'b0, 16'h0, 1'b1);
    check("halt_ign_start", 32'(halted), 32'd1);
    step(1'b0, 1'b1, 16'd0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check("resume_instr", 32'(out_instr), 32'h8808);

    // Running off the end of memory
    step(1'b0, 1'b1, 16'd998, 1'b1);
    c0 = m_count;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
    check("range_halt", 32'(halted), 32'd1);
    check("range_err", 32'(addr_err), 32'd1);
    check("range_pc", 32'(out_pc), 32'd999);
    check("range_count", 32'(fetch_count), 32'(c0 + 16'd2));
    step(1'b0, 1'b1, 16'd10, 1'b1);
    check("err_sticky", 32'(addr_err), 32'd1);

    // Async reset in the middle of a stall, then a start is required
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    do_reset();
    check("mid_rst_halted", 32'(halted), 32'd0);
    check("mid_rst_pc", 32'(imem_addr), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'd7, 1'b1);
    check("idle_no_fetch", 32'(fetch_count), 32'd0);

    // Randomized traffic with a few scattered halt words
    mem[4] = rand_word();
    for (int i = 0; i < 8; i++) mem[$urandom_range(0, 999)] = 16'hFFFF;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 15) == 0),
             ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1003)),
             ($urandom_range(0, 3) != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage sitting directly upstream of the 16-bit instruction memory. Holds the PC and drives the memory address.
- Captures the returned 16-bit instruction into an IF/ID output register with a valid/ready handshake toward decode.
- Handles start-up, backpressure stalls, control-flow redirects (branch/jump), halt detection and out-of-range PC.
- Instruction memory read is combinational: data for an address is valid in the same cycle.

Parameters:
- RESET_PC, 16'h0000, PC loaded on start.
- MEM_DEPTH, 1000, number of valid instruction words; addresses 0..MEM_DEPTH-1.
- HALT_WORD, 16'hFFFF, instruction encoding that stops fetching once captured.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins fetching from RESET_PC.
- imem_addr  out  16  address to instruction memory; always equals pc.
- imem_data  in  16  instruction word returned combinationally for imem_addr.
- redirect_valid  in  1  downstream requests a control-flow change this cycle.
- redirect_target  in  16  new PC when redirect_valid=1.
- out_valid  out  1  IF/ID register holds an instruction.
- out_ready  in  1  decode accepts out_instr this cycle.
- out_instr  out  16  fetched instruction.
- out_pc  out  16  address out_instr was fetched from.
- halted  out  1  high in HALTED state.
- addr_err  out  1  sticky; set when the PC reached MEM_DEPTH or beyond.
- fetch_count  out  16  number of instructions captured since reset; wraps at 16'hFFFF->0.

Behaviour:
- Reset (async): state=IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0, addr_err=0, fetch_count=0.
- States: IDLE, RUN, HALTED.
- IDLE:
  - No fetch; start=1 -> pc<=RESET_PC, state<=RUN.
  - redirect_valid is ignored.
- RUN: fetch_en = (!out_valid || out_ready). Priority order per cycle:
  1. redirect_valid=1: out_valid<=0 (flush; a simultaneously asserted out_ready still consumes the old word), pc<=redirect_target, no capture this cycle.
  2. pc >= MEM_DEPTH and fetch_en: state<=HALTED, addr_err<=1, out_valid<=0 if out_ready else hold, no capture.
  3. fetch_en: out_instr<=imem_data, out_pc<=pc, out_valid<=1, pc<=pc+1 (16-bit wrap), fetch_count<=fetch_count+1. If imem_data==HALT_WORD, state<=HALTED and pc is not incremented.
  4. Otherwise (out_valid && !out_ready): stall; pc, out_* and fetch_count all hold.
- Latency: the word at address A appears on out_instr the clock edge after pc==A with fetch_en=1. Sustained throughput is 1 instr/cycle while out_ready=1.
- HALTED:
  - halted=1; no fetch.
  - A pending out_valid word is held until out_ready, then out_valid<=0.
  - redirect_valid=1 -> pc<=redirect_target, out_valid<=0, state<=RUN. addr_err stays set.
  - start is ignored.
- start while in RUN is ignored.
- addr_err is cleared only by rst.
- Reset mid-operation: all state clears immediately, independent of clk. An in-flight out_valid word is discarded.

Test Plan:
- Reset, then start; memory[0..2]=16'h8808,16'h05F4,16'h8902; out_ready=1 -> out_instr 8808/05F4/8902 on 3 consecutive edges, out_pc 0/1/2, fetch_count=3.
- Backpressure: out_ready=0 for 3 cycles after the first capture -> out_instr stays 16'h8808, out_pc=0, imem_addr=1; release -> 16'h05F4 next edge, no word lost or duplicated.
- Redirect: redirect_valid=1, target=16'd255, while out_valid=1 with out_pc=5 -> next edge out_valid=0, pc=255; following edge out_instr=memory[255]=16'h8783, out_pc=255.
- Halt: memory[4]=16'hFFFF -> captured with out_pc=4, halted=1, imem_addr stays 4, no further fetch_count increments; redirect to 0 -> resumes RUN fetching 16'h8808.
- Range: redirect to 16'd998 with MEM_DEPTH=1000 -> addresses 998 and 999 captured, then halted=1, addr_err=1, fetch_count +2 only.
- Async reset asserted mid-stall (not on a clock edge) -> out_valid=0, halted=0, pc=RESET_PC immediately; start is required to restart.
